// File: rtl/decode_stage.sv
// Decode stage: 8-entry register file with write-to-read bypass, immediate
// extension, write-register selection, load-use hazard bubbling and a
// valid/ready output register that keeps held operands coherent with writeback.
//
// Ports
//   clk, rst                     clock, asynchronous active-low reset
//   in_valid/in_ready            upstream handshake (in_ready is combinational)
//   in_instr, in_pc, in_ctrl     instruction word, PC, opaque control bundle
//   in_use1/in_use2              instruction reads rs=[10:8] / rt=[7:5]
//   in_regwrite/in_memread       instruction writes a register / is a load
//   in_regdst, in_imm_sel,
//   in_imm_sext                  write-register and immediate decode controls
//   wb_en/wb_sel/wb_data         register-file write port
//   flush                        kill incoming and held instruction
//   out_valid/out_ready          downstream handshake
//   out_pc, out_rd1, out_rd2,
//   out_imm, out_wsel, out_ctrl,
//   out_regwrite, out_memread,
//   out_err                      registered decoded payload
module decode_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CTRL_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_use1,
    input  logic              in_use2,
    input  logic              in_regwrite,
    input  logic              in_memread,
    input  logic [1:0]        in_regdst,
    input  logic [1:0]        in_imm_sel,
    input  logic              in_imm_sext,
    input  logic              wb_en,
    input  logic [2:0]        wb_sel,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic [DATA_W-1:0] out_imm,
    output logic [2:0]        out_wsel,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              out_regwrite,
    output logic              out_memread,
    output logic              out_err
);
    localparam int unsigned REG_N = 8;
    localparam int unsigned SEL_W = 3;

    logic [DATA_W-1:0] r_rf [REG_N];

    logic              r_valid;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [SEL_W-1:0]  r_wsel;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_regwrite;
    logic              r_memread;
    logic              r_err;
    logic [SEL_W-1:0]  r_rs;
    logic [SEL_W-1:0]  r_rt;
    logic              r_use1;
    logic              r_use2;

    logic [SEL_W-1:0]  w_rs;
    logic [SEL_W-1:0]  w_rt;
    logic [SEL_W-1:0]  w_wsel;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] w_imm;
    logic              w_imm_err;
    logic              w_advance;
    logic              w_hazard;
    logic              w_unused;

    assign w_rs     = in_instr[10:8];
    assign w_rt     = in_instr[7:5];
    assign w_unused = ^in_instr[15:11];

    // Register read with same-cycle writeback bypass
    assign w_rd1 = (wb_en && (wb_sel == w_rs)) ? wb_data : r_rf[w_rs];
    assign w_rd2 = (wb_en && (wb_sel == w_rt)) ? wb_data : r_rf[w_rt];

    // Immediate extension; mode 11 is illegal and flags an error
    always_comb begin
        w_imm     = '0;
        w_imm_err = 1'b0;
        case (in_imm_sel)
            2'b00:   w_imm = {{(DATA_W-11){in_instr[10]}}, in_instr[10:0]};
            2'b01:   w_imm = {{(DATA_W-5){in_imm_sext & in_instr[4]}}, in_instr[4:0]};
            2'b10:   w_imm = {{(DATA_W-8){in_instr[7]}}, in_instr[7:0]};
            default: w_imm_err = 1'b1;
        endcase
    end

    // Write-register select
    always_comb begin
        w_wsel = in_instr[7:5];
        case (in_regdst)
            2'b00:   w_wsel = in_instr[4:2];
            2'b01:   w_wsel = SEL_W'(7);
            2'b10:   w_wsel = in_instr[10:8];
            default: w_wsel = in_instr[7:5];
        endcase
    end

    // Load-use hazard against the instruction sitting in the output register
    assign w_advance = !r_valid || out_ready;
    assign w_hazard  = in_valid && r_valid && r_memread && r_regwrite &&
                       ((in_use1 && (r_wsel == w_rs)) || (in_use2 && (r_wsel == w_rt)));
    assign in_ready  = flush || (w_advance && !w_hazard);

    // Register file
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_N; i++) begin
                r_rf[i] <= '0;
            end
        end else if (wb_en) begin
            r_rf[wb_sel] <= wb_data;
        end
    end

    // Output register: flush, bubble, load, or hold with operand refresh
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_wsel     <= '0;
            r_ctrl     <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_err      <= 1'b0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_use1     <= 1'b0;
            r_use2     <= 1'b0;
        end else if (flush || (w_advance && w_hazard)) begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_advance) begin
            r_valid    <= in_valid;
            r_pc       <= in_pc;
            r_rd1      <= w_rd1;
            r_rd2      <= w_rd2;
            r_imm      <= w_imm;
            r_wsel     <= w_wsel;
            r_ctrl     <= in_ctrl;
            r_regwrite <= in_regwrite;
            r_memread  <= in_memread;
            r_err      <= in_valid && w_imm_err;
            r_rs       <= w_rs;
            r_rt       <= w_rt;
            r_use1     <= in_use1;
            r_use2     <= in_use2;
        end else begin
            // Held instruction must see writebacks that land while stalled
            if (wb_en && r_use1 && (wb_sel == r_rs)) begin
                r_rd1 <= wb_data;
            end
            if (wb_en && r_use2 && (wb_sel == r_rt)) begin
                r_rd2 <= wb_data;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_pc       = r_pc;
    assign out_rd1      = r_rd1;
    assign out_rd2      = r_rd2;
    assign out_imm      = r_imm;
    assign out_wsel     = r_wsel;
    assign out_ctrl     = r_ctrl;
    assign out_regwrite = r_regwrite;
    assign out_memread  = r_memread;
    assign out_err      = r_err;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios followed by random traffic,
// all checked against a transaction-level model of the stage.
module tb_decode_stage;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid, in_ready;
    logic [15:0]   in_instr;
    logic [DW-1:0] in_pc;
    logic [CW-1:0] in_ctrl;
    logic          in_use1, in_use2, in_regwrite, in_memread;
    logic [1:0]    in_regdst, in_imm_sel;
    logic          in_imm_sext;
    logic          wb_en;
    logic [2:0]    wb_sel;
    logic [DW-1:0] wb_data;
    logic          flush;
    logic          out_valid, out_ready;
    logic [DW-1:0] out_pc, out_rd1, out_rd2, out_imm;
    logic [2:0]    out_wsel;
    logic [CW-1:0] out_ctrl;
    logic          out_regwrite, out_memread, out_err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: architectural registers and the instruction
    // currently presented downstream
    logic [DW-1:0] m_rf [8];
    logic          m_valid;
    logic [DW-1:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [2:0]    m_wsel, m_rs, m_rt;
    logic [CW-1:0] m_ctrl;
    logic          m_rw, m_mr, m_err, m_u1, m_u2;

    decode_stage #(.DATA_W(DW), .CTRL_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .in_ctrl(in_ctrl), .in_use1(in_use1), .in_use2(in_use2),
        .in_regwrite(in_regwrite), .in_memread(in_memread), .in_regdst(in_regdst),
        .in_imm_sel(in_imm_sel), .in_imm_sext(in_imm_sext),
        .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
        .out_wsel(out_wsel), .out_ctrl(out_ctrl), .out_regwrite(out_regwrite),
        .out_memread(out_memread), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Immediate value computed as a signed integer, then wrapped to DW bits
    function automatic logic [DW-1:0] ref_imm(input logic [15:0] ins, input logic [1:0] sel,
                                             input logic sx, output logic err);
        int v;
        err = 1'b0;
        case (sel)
            2'd0: begin v = int'(ins[10:0]); if (v >= 1024) v = v - 2048; end
            2'd1: begin v = int'(ins[4:0]);  if (sx && v >= 16) v = v - 32; end
            2'd2: begin v = int'(ins[7:0]);  if (v >= 128) v = v - 256; end
            default: begin v = 0; err = 1'b1; end
        endcase
        return DW'(v);
    endfunction

    function automatic logic [2:0] ref_wsel(input logic [15:0] ins, input logic [1:0] rd);
        case (rd)
            2'd0:    return ins[4:2];
            2'd1:    return 3'd7;
            2'd2:    return ins[10:8];
            default: return ins[7:5];
        endcase
    endfunction

    function automatic logic [DW-1:0] ref_read(input logic [2:0] idx);
        return (wb_en && wb_sel == idx) ? wb_data : m_rf[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_valid = 0; m_pc = '0; m_rd1 = '0; m_rd2 = '0; m_imm = '0;
        m_wsel = '0; m_rs = '0; m_rt = '0; m_ctrl = '0;
        m_rw = 0; m_mr = 0; m_err = 0; m_u1 = 0; m_u2 = 0;
    endtask

    // One clock edge of the model, using the inputs currently applied
    task automatic model_edge(input logic adv, input logic hz);
        logic e;
        if (flush || (adv && hz)) begin
            m_valid = 1'b0;
        end else if (adv) begin
            m_valid = in_valid;
            m_pc    = in_pc;
            m_rs    = in_instr[10:8];
            m_rt    = in_instr[7:5];
            m_rd1   = ref_read(m_rs);
            m_rd2   = ref_read(m_rt);
            m_imm   = ref_imm(in_instr, in_imm_sel, in_imm_sext, e);
            m_err   = e;
            m_wsel  = ref_wsel(in_instr, in_regdst);
            m_ctrl  = in_ctrl;
            m_rw    = in_regwrite;
            m_mr    = in_memread;
            m_u1    = in_use1;
            m_u2    = in_use2;
        end else if (wb_en) begin
            if (m_u1 && wb_sel == m_rs) m_rd1 = wb_data;
            if (m_u2 && wb_sel == m_rt) m_rd2 = wb_data;
        end
        if (wb_en) m_rf[wb_sel] = wb_data;
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, m_valid);
        if (m_valid) begin
            check("out_pc", out_pc, m_pc);
            check("out_rd1", out_rd1, m_rd1);
            check("out_rd2", out_rd2, m_rd2);
            check("out_imm", out_imm, m_imm);
            check("out_wsel", out_wsel, m_wsel);
            check("out_ctrl", out_ctrl, m_ctrl);
            check("out_regwrite", out_regwrite, m_rw);
            check("out_memread", out_memread, m_mr);
            check("out_err", out_err, m_err);
        end
    endtask

    // Called just after inputs are driven (away from the rising edge)
    task automatic cycle();
        logic adv, hz;
        #1;
        adv = !m_valid || out_ready;
        hz  = in_valid && m_valid && m_mr && m_rw &&
              ((in_use1 && m_wsel == in_instr[10:8]) || (in_use2 && m_wsel == in_instr[7:5]));
        check("in_ready", in_ready, flush || (adv && !hz));
        @(posedge clk);
        model_edge(adv, hz);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_instr = '0; in_pc = '0; in_ctrl = '0;
        in_use1 = 0; in_use2 = 0; in_regwrite = 0; in_memread = 0;
        in_regdst = 2'd3; in_imm_sel = 2'd0; in_imm_sext = 0;
        wb_en = 0; wb_sel = '0; wb_data = '0; flush = 0; out_ready = 1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [DW-1:0] pc,
                         input logic u1, u2, rw, mr, input logic [1:0] rd, is, input logic sx);
        in_valid = v; in_instr = ins; in_pc = pc; in_ctrl = CW'(pc ^ 16'h5A5A);
        in_use1 = u1; in_use2 = u2; in_regwrite = rw; in_memread = mr;
        in_regdst = rd; in_imm_sel = is; in_imm_sext = sx;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        model_reset();
        check("rst out_valid", out_valid, 1'b0);
        check("rst in_ready", in_ready, 1'b1);
        check("rst out_pc", out_pc, '0);
        check("rst out_rd1", out_rd1, '0);
        check("rst out_rd2", out_rd2, '0);
        check("rst out_imm", out_imm, '0);
        check("rst out_ctrl", out_ctrl, '0);
        check("rst flags", {out_wsel, out_regwrite, out_memread, out_err}, '0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post-rst in_ready", in_ready, 1'b1);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        do_reset();

        // Written register read back by a later instruction
        idle_inputs(); wb_en = 1; wb_sel = 3'd3; wb_data = 16'h1234; cycle();
        idle_inputs(); drive(1, 16'h0300, 16'h0100, 1, 0, 0, 0, 2'd3, 2'd0, 0); cycle();
        check("rs3 readback", out_rd1, 16'h1234);

        // Same-cycle bypass on rt
        idle_inputs(); drive(1, 16'h0040, 16'h0102, 0, 1, 0, 0, 2'd3, 2'd0, 0);
        wb_en = 1; wb_sel = 3'd2; wb_data = 16'hBEEF; cycle();
        check("rt2 bypass", out_rd2, 16'hBEEF);

        // Load writing r4, then a consumer of r4: one bubble
        idle_inputs(); drive(1, 16'h0010, 16'h0104, 0, 0, 1, 1, 2'd0, 2'd0, 0); cycle();
        check("load wsel", out_wsel, 3'd4);
        idle_inputs(); drive(1, 16'h0400, 16'h0106, 1, 0, 0, 0, 2'd3, 2'd0, 0); #1;
        check("hazard in_ready", in_ready, 1'b0);
        cycle();
        check("bubble", out_valid, 1'b0);
        check("after bubble in_ready", in_ready, 1'b1);
        cycle();
        check("accepted pc", out_pc, 16'h0106);

        // Hold with writeback refresh of the held rs operand
        idle_inputs(); drive(1, 16'h0500, 16'h0055, 1, 0, 0, 0, 2'd3, 2'd0, 0); cycle();
        idle_inputs(); out_ready = 0; wb_en = 1; wb_sel = 3'd5; wb_data = 16'h00AA; cycle();
        check("held rd1 refresh", out_rd1, 16'h00AA);
        check("held pc", out_pc, 16'h0055);
        idle_inputs(); out_ready = 0; cycle();

        // Immediate mode 01 both extensions, then illegal mode
        idle_inputs(); drive(1, 16'h0010, 16'h0200, 0, 0, 0, 0, 2'd3, 2'd1, 1); cycle();
        check("imm sext", out_imm, 16'hFFF0);
        idle_inputs(); drive(1, 16'h0010, 16'h0202, 0, 0, 0, 0, 2'd3, 2'd1, 0); cycle();
        check("imm zext", out_imm, 16'h0010);
        idle_inputs(); drive(1, 16'h0010, 16'h0204, 0, 0, 0, 0, 2'd3, 2'd3, 0); cycle();
        check("imm illegal err", out_err, 1'b1);

        // Flush overrides hazard and hold
        idle_inputs(); drive(1, 16'h0010, 16'h0300, 0, 0, 1, 1, 2'd0, 2'd0, 0); cycle();
        idle_inputs(); drive(1, 16'h0400, 16'h0302, 1, 0, 0, 0, 2'd3, 2'd0, 0);
        out_ready = 0; flush = 1; #1;
        check("flush in_ready", in_ready, 1'b1);
        cycle();
        check("flush kills", out_valid, 1'b0);

        // Random traffic, with one reset in the middle
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            in_valid    = ($urandom_range(0, 9) < 7);
            in_instr    = 16'($urandom);
            in_pc       = DW'($urandom);
            in_ctrl     = CW'($urandom);
            in_use1     = 1'($urandom);
            in_use2     = 1'($urandom);
            in_regwrite = 1'($urandom);
            in_memread  = 1'($urandom);
            in_regdst   = 2'($urandom);
            in_imm_sel  = 2'($urandom);
            in_imm_sext = 1'($urandom);
            wb_en       = 1'($urandom);
            wb_sel      = 3'($urandom);
            wb_data     = DW'($urandom);
            flush       = ($urandom_range(0, 9) == 0);
            out_ready   = ($urandom_range(0, 9) < 6);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
